// File: rtl/tron_mmio_pkg.sv
// tron_mmio_pkg: register offsets within the tron MMIO window.
package tron_mmio_pkg;
  localparam logic [3:0] OFF_SW_VAL  = 4'd0;
  localparam logic [3:0] OFF_SW_EDGE = 4'd4;
  localparam logic [3:0] OFF_LED     = 4'd8;
  localparam logic [3:0] OFF_CTRL    = 4'd12;
  localparam logic [3:0] OFF_STATUS  = 4'd13;
  localparam int WIN_WORDS   = 16;
  localparam int CTRL_DEB_EN = 0;
endpackage

// File: rtl/tron_sw_debouncer.sv
// tron_sw_debouncer: 2-flop synchroniser, stability debounce and rise detect for one switch channel.
module tron_sw_debouncer #(
  parameter int CH_W       = 8,
  parameter int DEB_CYCLES = 250000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            deb_en_i,
  input  logic [CH_W-1:0] raw_i,
  output logic [CH_W-1:0] stable_o,
  output logic [CH_W-1:0] rise_o
);
  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
  logic [CH_W-1:0] sync1_q, sync2_q, stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done;
  always_comb begin
    done = cnt_q == LAST;
    stable_d = (!deb_en_i || (sync2_q != stable_q && done)) ? sync2_q : stable_q;
    cnt_d = (!deb_en_i || sync2_q == stable_q || done) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end
  assign stable_o = stable_q;
  assign rise_o   = stable_d & ~stable_q;
endmodule

// File: rtl/tron_mmio_bridge.sv
// tron_mmio_bridge: CPU-to-exmem bridge serving a 16-word switch/LED window, passing everything else to memory.
module tron_mmio_bridge
  import tron_mmio_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter logic [DATA_W-1:0] IO_BASE    = 16'hFFF0,
  parameter int                NUM_IN     = 2,
  parameter int                NUM_OUT    = 2,
  parameter int                CH_W       = 8,
  parameter int                DEB_CYCLES = 250000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  input  logic                    cpu_we,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic [DATA_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_we,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic [NUM_IN*CH_W-1:0]  sw_in,
  output logic [NUM_OUT*CH_W-1:0] led_out,
  output logic                    edge_any
);
  logic hit, wr;
  logic [3:0] off;
  logic [1:0] grp, ch;
  logic deb_en_q;
  logic [4*CH_W-1:0] val_v, edge_v, led_v;
  logic [CH_W-1:0] sel;
  logic [DATA_W-1:0] rd;
  logic unused_ok;
  assign hit       = cpu_addr[DATA_W-1:4] == IO_BASE[DATA_W-1:4];
  assign off       = cpu_addr[3:0];
  assign grp       = off[3:2];
  assign ch        = off[1:0];
  assign wr        = hit & cpu_we;
  assign mem_addr  = cpu_addr;
  assign mem_wdata = cpu_wdata;
  assign mem_we    = cpu_we & ~hit;
  assign unused_ok = ^cpu_wdata;
  // Channels are padded to four so the read mux can index by offset directly.
  for (genvar g = 0; g < 4; g++) begin : g_ch
    if (g < NUM_IN) begin : g_in
      logic [CH_W-1:0] stable, rise, clr, edge_q;
      tron_sw_debouncer #(.CH_W(CH_W), .DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk(clk), .reset(reset), .deb_en_i(deb_en_q),
        .raw_i(sw_in[g*CH_W +: CH_W]), .stable_o(stable), .rise_o(rise));
      assign clr = (wr && grp == OFF_SW_EDGE[3:2] && ch == 2'(g)) ? cpu_wdata[CH_W-1:0] : '0;
      always_ff @(posedge clk) edge_q <= reset ? '0 : (edge_q & ~clr) | rise;
      assign val_v[g*CH_W +: CH_W]  = stable;
      assign edge_v[g*CH_W +: CH_W] = edge_q;
    end else begin : g_no_in
      assign val_v[g*CH_W +: CH_W]  = '0;
      assign edge_v[g*CH_W +: CH_W] = '0;
    end
    if (g < NUM_OUT) begin : g_out
      logic [CH_W-1:0] led_q;
      always_ff @(posedge clk)
        if (reset) led_q <= '0;
        else if (wr && grp == OFF_LED[3:2] && ch == 2'(g)) led_q <= cpu_wdata[CH_W-1:0];
      assign led_v[g*CH_W +: CH_W] = led_q;
    end else begin : g_no_out
      assign led_v[g*CH_W +: CH_W] = '0;
    end
  end
  always_ff @(posedge clk)
    if (reset) deb_en_q <= 1'b1;
    else if (wr && off == OFF_CTRL) deb_en_q <= cpu_wdata[CTRL_DEB_EN];
  always_comb begin
    sel = grp == OFF_SW_VAL[3:2] ? val_v[ch*CH_W +: CH_W] :
          grp == OFF_SW_EDGE[3:2] ? edge_v[ch*CH_W +: CH_W] : led_v[ch*CH_W +: CH_W];
    rd = grp != OFF_CTRL[3:2] ? DATA_W'(sel) :
         off == OFF_CTRL ? DATA_W'(deb_en_q) :
         off == OFF_STATUS ? DATA_W'(edge_any) : '0;
  end
  assign cpu_rdata = hit ? rd : mem_rdata;
  assign led_out   = led_v[NUM_OUT*CH_W-1:0];
  assign edge_any  = |edge_v;
endmodule
